// File: rtl/core_pkg.sv
// Shared definitions for the pipeline sequencing controller.
//   - state_t       : controller FSM state encoding
//   - stage_ctrl_t  : per-stage enable/flush bundle driven to the pipeline
//   - CTRL_*        : the stage-control patterns the controller can select
//   - REG_ZERO      : x0, which never carries a real dependency
//   - load_use_hit  : RAW check between a load in EX and the ID operands
package core_pkg;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Cycles spent emptying EX/MEM/WB after an ecall/ebreak leaves EX.
    localparam logic [1:0] DRAIN_LEN = 2'd2;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_HALTED   = 3'd3,
        ST_FAULT    = 3'd4
    } state_t;

    // Field order fixes the bit layout of the CTRL_* constants below (MSB first).
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic mem_wb_en;
    } stage_ctrl_t;

    // Everything stopped, both front-end registers forced to bubbles.
    localparam stage_ctrl_t CTRL_STOP       = 7'b0010100;
    // Whole pipeline holds its contents (data-memory wait).
    localparam stage_ctrl_t CTRL_FREEZE     = 7'b0000000;
    // PC held, front end squashed, back end keeps retiring.
    localparam stage_ctrl_t CTRL_DRAIN      = 7'b0111111;
    // New PC taken, both wrong-path instructions squashed.
    localparam stage_ctrl_t CTRL_REDIRECT   = 7'b1111111;
    // PC and IF/ID hold, one bubble enters EX.
    localparam stage_ctrl_t CTRL_LOAD_USE   = 7'b0001111;
    // Fetch not ready: PC holds, IF/ID takes a bubble, rest advances.
    localparam stage_ctrl_t CTRL_FETCH_WAIT = 7'b0111011;
    localparam stage_ctrl_t CTRL_NORMAL     = 7'b1101011;

    function automatic logic load_use_hit(
        input logic       ex_mem_read,
        input logic [4:0] ex_rd_addr,
        input logic       id_uses_rs1,
        input logic [4:0] id_rs1_addr,
        input logic       id_uses_rs2,
        input logic [4:0] id_rs2_addr
    );
        return ex_mem_read && (ex_rd_addr != REG_ZERO) &&
               ((id_uses_rs1 && (id_rs1_addr == ex_rd_addr)) ||
                (id_uses_rs2 && (id_rs2_addr == ex_rd_addr)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the performance counters.
//   clk   : clock
//   clr   : synchronous clear (highest priority)
//   inc   : count this cycle
//   count : current value, sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core.
// Produces per-stage enables/flushes for load-use bubbles, redirect flushes,
// instruction/data memory waits and the ecall/ebreak drain-and-halt, plus a
// data-memory timeout watchdog and saturating stall/flush counters.
//   clk, rst                 : clock, synchronous active-high reset
//   id_rs1/rs2_addr, uses    : operands of the instruction in ID
//   ex_mem_read, ex_rd_addr  : load flag and destination of the EX instruction
//   ex_redirect, ex_halt     : taken control transfer / ecall-ebreak in EX
//   imem_ready               : fetch data valid
//   dmem_req, dmem_ready     : MEM-stage data access and its completion
//   pc_en .. mem_wb_en       : stage register enables and bubble inserts
//   halted, mem_fault        : sticky status, cleared only by rst
//   stall_cnt, flush_cnt     : saturating performance counters
module hazard_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W        = 32,
    parameter int DMEM_TIMEOUT = 255,
    parameter int TO_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1_addr,
    input  logic [4:0]       id_rs2_addr,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_redirect,
    input  logic             ex_halt,
    input  logic             imem_ready,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             halted,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [TO_W-1:0] TIMEOUT_LIMIT = TO_W'(DMEM_TIMEOUT);

    state_t          state_reg, state_next;
    logic [TO_W-1:0] wait_reg, wait_next;
    logic [1:0]      drain_reg, drain_next;

    logic        lu;
    logic        mw;
    stage_ctrl_t run_ctrl;
    state_t      run_next;
    stage_ctrl_t ctrl;

    assign lu = load_use_hit(ex_mem_read, ex_rd_addr, id_uses_rs1, id_rs1_addr,
                             id_uses_rs2, id_rs2_addr);
    assign mw = dmem_req && !dmem_ready;

    // Normal-flow decision once no data-memory wait is pending. Halt outranks
    // redirect, and redirect outranks the load-use stall because the
    // dependent instruction in ID is on the wrong path anyway.
    always_comb begin
        run_ctrl = CTRL_NORMAL;
        run_next = ST_RUN;
        if (ex_halt) begin
            run_ctrl = CTRL_DRAIN;
            run_next = ST_DRAIN;
        end else if (ex_redirect) begin
            run_ctrl = CTRL_REDIRECT;
        end else if (lu) begin
            run_ctrl = CTRL_LOAD_USE;
        end else if (!imem_ready) begin
            run_ctrl = CTRL_FETCH_WAIT;
        end
    end

    always_comb begin
        ctrl       = CTRL_STOP;
        state_next = state_reg;
        wait_next  = wait_reg;
        drain_next = drain_reg;
        case (state_reg)
            ST_RUN, ST_MEM_WAIT: begin
                if (mw) begin
                    ctrl = CTRL_FREEZE;
                    if (state_reg == ST_RUN) begin
                        state_next = ST_MEM_WAIT;
                        wait_next  = TO_W'(1);
                    end else if (wait_reg >= TIMEOUT_LIMIT) begin
                        state_next = ST_FAULT;
                    end else begin
                        wait_next = wait_reg + TO_W'(1);
                    end
                end else begin
                    // The completing cycle of a wait is an ordinary RUN cycle.
                    ctrl       = run_ctrl;
                    state_next = run_next;
                    wait_next  = '0;
                    if (run_next == ST_DRAIN) begin
                        drain_next = DRAIN_LEN;
                    end
                end
            end
            ST_DRAIN: begin
                if (mw) begin
                    ctrl = CTRL_FREEZE;
                end else begin
                    ctrl = CTRL_DRAIN;
                    if (drain_reg <= 2'd1) begin
                        drain_next = '0;
                        state_next = ST_HALTED;
                    end else begin
                        drain_next = drain_reg - 2'd1;
                    end
                end
            end
            default: begin
                ctrl = CTRL_STOP;
            end
        endcase
        // Reset overrides immediately so nothing advances during the reset cycle.
        if (rst) begin
            ctrl = CTRL_STOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RUN;
            wait_reg  <= '0;
            drain_reg <= '0;
        end else begin
            state_reg <= state_next;
            wait_reg  <= wait_next;
            drain_reg <= drain_next;
        end
    end

    assign pc_en       = ctrl.pc_en;
    assign if_id_en    = ctrl.if_id_en;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_en    = ctrl.id_ex_en;
    assign id_ex_flush = ctrl.id_ex_flush;
    assign ex_mem_en   = ctrl.ex_mem_en;
    assign mem_wb_en   = ctrl.mem_wb_en;

    // HALTED and FAULT are terminal until reset, so the state itself is the flag.
    assign halted    = !rst && (state_reg == ST_HALTED);
    assign mem_fault = !rst && (state_reg == ST_FAULT);

    // Index 0: stall cycles (front end held during normal operation).
    // Index 1: bubbles inserted into EX.
    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = ((state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT)) && !ctrl.pc_en;
    assign cnt_inc[1] = ctrl.id_ex_flush;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_perf_cnt
            sat_counter #(
                .W(CNT_W)
            ) u_cnt (
                .clk  (clk),
                .clr  (rst),
                .inc  (cnt_inc[gi]),
                .count(cnt_val[gi])
            );
        end
    endgenerate

    assign stall_cnt = rst ? '0 : cnt_val[0];
    assign flush_cnt = rst ? '0 : cnt_val[1];

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    localparam int CNT_W        = 4;
    localparam int DMEM_TIMEOUT = 4;
    localparam int TO_W         = 16;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    // Pattern order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en}
    localparam logic [6:0] P_STOP   = 7'b0010100;
    localparam logic [6:0] P_FREEZE = 7'b0000000;
    localparam logic [6:0] P_DRAIN  = 7'b0111111;
    localparam logic [6:0] P_REDIR  = 7'b1111111;
    localparam logic [6:0] P_LU     = 7'b0001111;
    localparam logic [6:0] P_FETCH  = 7'b0111011;
    localparam logic [6:0] P_NORM   = 7'b1101011;

    logic clk;
    logic rst;
    logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, ex_halt;
    logic imem_ready, dmem_req, dmem_ready;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic halted, mem_fault;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [6:0] dut_ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_stall, m_flush, m_streak, m_drain;
    bit m_halted, m_fault;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl #(
        .CNT_W(CNT_W),
        .DMEM_TIMEOUT(DMEM_TIMEOUT),
        .TO_W(TO_W)
    ) dut (
        .clk(clk), .rst(rst),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
        .ex_redirect(ex_redirect), .ex_halt(ex_halt),
        .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .halted(halted), .mem_fault(mem_fault),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign dut_ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected controls straight from the priority rules.
    function automatic logic [6:0] model_ctrl();
        logic lu_v;
        logic mw_v;
        mw_v = dmem_req && !dmem_ready;
        lu_v = ex_mem_read && (ex_rd_addr != 5'd0) &&
               ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
                (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
        if (rst || m_halted || m_fault) return P_STOP;
        if (mw_v)                       return P_FREEZE;
        if (m_drain > 0 || ex_halt)     return P_DRAIN;
        if (ex_redirect)                return P_REDIR;
        if (lu_v)                       return P_LU;
        if (!imem_ready)                return P_FETCH;
        return P_NORM;
    endfunction

    task automatic model_update();
        logic [6:0] c;
        logic mw_v;
        c    = model_ctrl();
        mw_v = dmem_req && !dmem_ready;
        if (rst) begin
            m_stall = 0; m_flush = 0; m_streak = 0; m_drain = 0;
            m_halted = 0; m_fault = 0;
            return;
        end
        if (!m_halted && !m_fault && m_drain == 0 && !c[6] && m_stall < CNT_MAX) m_stall++;
        if (c[2] && m_flush < CNT_MAX) m_flush++;
        if (!m_halted && !m_fault) begin
            if (m_drain > 0) begin
                if (!mw_v) begin
                    m_drain--;
                    if (m_drain == 0) m_halted = 1;
                end
            end else if (mw_v) begin
                // streak = consecutive wait cycles already seen before this one
                if (m_streak == DMEM_TIMEOUT) m_fault = 1;
                else m_streak++;
            end else begin
                m_streak = 0;
                if (ex_halt) m_drain = 2;
            end
        end
    endtask

    task automatic idle_inputs();
        id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; ex_rd_addr = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_redirect = 1'b0; ex_halt = 1'b0;
        imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Compare every output against the model at the falling edge.
    task automatic sample(input string tag);
        @(negedge clk);
        check({tag, ".ctrl"}, 32'(dut_ctrl), 32'(model_ctrl()));
        check({tag, ".halted"}, 32'(halted), 32'(!rst && m_halted));
        check({tag, ".mem_fault"}, 32'(mem_fault), 32'(!rst && m_fault));
        check({tag, ".stall_cnt"}, 32'(stall_cnt), rst ? 32'd0 : 32'(m_stall));
        check({tag, ".flush_cnt"}, 32'(flush_cnt), rst ? 32'd0 : 32'(m_flush));
        $display("[%0t] %s rst=%0b ctrl=%b halted=%0b fault=%0b stall=%0d flush=%0d",
                 $time, tag, rst, dut_ctrl, halted, mem_fault, stall_cnt, flush_cnt);
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        sample("reset");
        check("reset.ctrl_const", 32'(dut_ctrl), 32'(P_STOP));
        advance();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       u1, u2, mr, redir, imem;
        logic [4:0] rs1, rs2, rd;
        logic [6:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // Single-cycle patterns from RUN; none of them leaves RUN.
        vecs[0] = '{u1:0, u2:0, mr:0, redir:0, imem:1, rs1:0, rs2:0, rd:0, exp:P_NORM};
        vecs[1] = '{u1:0, u2:1, mr:1, redir:0, imem:1, rs1:0, rs2:5, rd:5, exp:P_LU};
        vecs[2] = '{u1:1, u2:1, mr:1, redir:0, imem:1, rs1:0, rs2:0, rd:0, exp:P_NORM};
        vecs[3] = '{u1:0, u2:1, mr:1, redir:1, imem:1, rs1:0, rs2:5, rd:5, exp:P_REDIR};
        vecs[4] = '{u1:0, u2:1, mr:1, redir:0, imem:1, rs1:7, rs2:3, rd:7, exp:P_NORM};
        vecs[5] = '{u1:1, u2:0, mr:1, redir:0, imem:1, rs1:7, rs2:3, rd:7, exp:P_LU};
        vecs[6] = '{u1:0, u2:0, mr:0, redir:0, imem:0, rs1:0, rs2:0, rd:0, exp:P_FETCH};
        vecs[7] = '{u1:1, u2:0, mr:1, redir:0, imem:0, rs1:9, rs2:0, rd:9, exp:P_LU};
        vecs[8] = '{u1:0, u2:0, mr:0, redir:1, imem:0, rs1:0, rs2:0, rd:0, exp:P_REDIR};
        vecs[9] = '{u1:1, u2:1, mr:0, redir:0, imem:1, rs1:4, rs2:4, rd:4, exp:P_NORM};

        m_stall = 0; m_flush = 0; m_streak = 0; m_drain = 0; m_halted = 0; m_fault = 0;
        idle_inputs();
        rst = 1'b1;
        advance();
        do_reset();

        // ---------------- table vectors ----------------
        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            id_uses_rs1 = vecs[i].u1; id_uses_rs2 = vecs[i].u2;
            ex_mem_read = vecs[i].mr; ex_redirect = vecs[i].redir;
            imem_ready  = vecs[i].imem;
            id_rs1_addr = vecs[i].rs1; id_rs2_addr = vecs[i].rs2; ex_rd_addr = vecs[i].rd;
            sample($sformatf("vec%0d", i));
            check($sformatf("vec%0d.table", i), 32'(dut_ctrl), 32'(vecs[i].exp));
            advance();
        end

        // ---------------- load-use: one bubble ----------------
        do_reset();
        ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_uses_rs2 = 1'b1; id_rs2_addr = 5'd5;
        sample("lu.stall");
        check("lu.stall_pat", 32'(dut_ctrl), 32'(P_LU));
        advance();
        idle_inputs();
        sample("lu.resume");
        check("lu.resume_pat", 32'(dut_ctrl), 32'(P_NORM));
        check("lu.stall_cnt", 32'(stall_cnt), 32'd1);
        check("lu.flush_cnt", 32'(flush_cnt), 32'd1);
        advance();

        // ---------------- data-memory wait of 3 cycles ----------------
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample($sformatf("mw.wait%0d", k));
            check("mw.freeze", 32'(dut_ctrl), 32'(P_FREEZE));
            advance();
        end
        dmem_ready = 1'b1;
        sample("mw.done");
        check("mw.done_pat", 32'(dut_ctrl), 32'(P_NORM));
        advance();
        idle_inputs();
        sample("mw.after");
        check("mw.stall_cnt", 32'(stall_cnt), 32'd3);
        check("mw.flush_cnt", 32'(flush_cnt), 32'd0);
        advance();

        // ---------------- timeout ----------------
        do_reset();
        dmem_req = 1'b1; dmem_ready = 1'b0;
        for (int k = 0; k <= DMEM_TIMEOUT; k++) begin
            sample($sformatf("to.wait%0d", k));
            check("to.no_fault_yet", 32'(mem_fault), 32'd0);
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 1) idle_inputs();
            sample($sformatf("to.fault%0d", k));
            check("to.mem_fault", 32'(mem_fault), 32'd1);
            check("to.stopped", 32'(dut_ctrl), 32'(P_STOP));
            advance();
        end
        do_reset();
        sample("to.cleared");
        check("to.fault_cleared", 32'(mem_fault), 32'd0);
        advance();

        // ---------------- halt (with redirect) then drain ----------------
        ex_halt = 1'b1; ex_redirect = 1'b1;
        sample("halt.ex");
        check("halt.wins", 32'(dut_ctrl), 32'(P_DRAIN));
        advance();
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            sample($sformatf("halt.drain%0d", k));
            check("halt.drain_pat", 32'(dut_ctrl), 32'(P_DRAIN));
            check("halt.not_yet", 32'(halted), 32'd0);
            advance();
        end
        sample("halt.halted");
        check("halt.halted", 32'(halted), 32'd1);
        check("halt.stop_pat", 32'(dut_ctrl), 32'(P_STOP));
        advance();
        for (int k = 0; k < 16; k++) begin
            sample("halt.hold");
            advance();
        end
        check("halt.flush_sat", 32'(flush_cnt), 32'(CNT_MAX));
        rst = 1'b1;
        sample("halt.rst");
        check("halt.rst_halted", 32'(halted), 32'd0);
        advance();
        rst = 1'b0;
        sample("halt.run");
        check("halt.run_pat", 32'(dut_ctrl), 32'(P_NORM));
        check("halt.run_halted", 32'(halted), 32'd0);
        advance();

        // ---------------- reset in the middle of a drain ----------------
        ex_halt = 1'b1;
        sample("mid.halt");
        advance();
        idle_inputs();
        sample("mid.drain");
        advance();
        rst = 1'b1;
        sample("mid.rst");
        advance();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample($sformatf("mid.after%0d", k));
            check("mid.normal", 32'(dut_ctrl), 32'(P_NORM));
            check("mid.not_halted", 32'(halted), 32'd0);
            advance();
        end

        // ---------------- randomized against the model ----------------
        for (int k = 0; k < 400; k++) begin
            rst         = ($urandom_range(0, 24) == 0);
            id_rs1_addr = 5'($urandom_range(0, 7));
            id_rs2_addr = 5'($urandom_range(0, 7));
            ex_rd_addr  = 5'($urandom_range(0, 7));
            id_uses_rs1 = 1'($urandom_range(0, 1));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 7) == 0);
            ex_halt     = ($urandom_range(0, 19) == 0);
            imem_ready  = ($urandom_range(0, 5) != 0);
            dmem_req    = ($urandom_range(0, 2) == 0);
            dmem_ready  = 1'($urandom_range(0, 1));
            sample($sformatf("rnd%0d", k));
            advance();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
